// File: rtl/tube_pkg.sv
// Shared types and constants for the seven-segment time display:
// segment codes, the 4-bit digit code, field limits and the BCD split helper.
package tube_pkg;

  localparam int unsigned FIELD_W = 6;
  localparam int unsigned SEG_W   = 8;
  localparam int unsigned IDX_W   = 3;

  localparam logic [SEG_W-1:0] SEG_0    = 8'h3F;
  localparam logic [SEG_W-1:0] SEG_1    = 8'h06;
  localparam logic [SEG_W-1:0] SEG_2    = 8'h5B;
  localparam logic [SEG_W-1:0] SEG_3    = 8'h4F;
  localparam logic [SEG_W-1:0] SEG_4    = 8'h66;
  localparam logic [SEG_W-1:0] SEG_5    = 8'h6D;
  localparam logic [SEG_W-1:0] SEG_6    = 8'h7D;
  localparam logic [SEG_W-1:0] SEG_7    = 8'h07;
  localparam logic [SEG_W-1:0] SEG_8    = 8'h7F;
  localparam logic [SEG_W-1:0] SEG_9    = 8'h6F;
  localparam logic [SEG_W-1:0] SEG_DASH = 8'h40;
  localparam logic [SEG_W-1:0] SEG_E    = 8'h79;
  localparam logic [SEG_W-1:0] SEG_OFF  = 8'h00;

  localparam logic [FIELD_W-1:0] HOUR_MAX = 6'd23;
  localparam logic [FIELD_W-1:0] MIN_MAX  = 6'd59;

  typedef enum logic [3:0] {
    DIG_0    = 4'd0,
    DIG_1    = 4'd1,
    DIG_2    = 4'd2,
    DIG_3    = 4'd3,
    DIG_4    = 4'd4,
    DIG_5    = 4'd5,
    DIG_6    = 4'd6,
    DIG_7    = 4'd7,
    DIG_8    = 4'd8,
    DIG_9    = 4'd9,
    DIG_DASH = 4'd10,
    DIG_E    = 4'd11,
    DIG_OFF  = 4'd15
  } digit_e;

  typedef struct packed {
    digit_e tens;
    digit_e units;
  } field_digits_t;

  // Split a 6-bit field into two digit codes; (v*205)>>11 is exact v/10 for v < 64.
  function automatic field_digits_t split_field(input logic [FIELD_W-1:0] v,
                                                input logic [FIELD_W-1:0] max_v);
    logic [13:0]   prod;
    logic [3:0]    tens;
    logic [3:0]    units;
    field_digits_t r;
    prod  = 14'(v) * 14'd205;
    tens  = 4'(prod >> 11);
    units = 4'(v - 6'(tens) * 6'd10);
    if (v > max_v) begin
      r = '{tens: DIG_E, units: DIG_E};
    end else begin
      r = '{tens: digit_e'(tens), units: digit_e'(units)};
    end
    return r;
  endfunction

endpackage

// File: rtl/tube_seg_decode.sv
// Combinational digit-code to segment-pattern decoder ({dp,g,f,e,d,c,b,a}, active-high).
module tube_seg_decode
  import tube_pkg::*;
(
  input  digit_e             code,
  output logic [SEG_W-1:0]   seg_c
);

  always_comb begin
    seg_c = SEG_OFF;
    case (code)
      DIG_0:    seg_c = SEG_0;
      DIG_1:    seg_c = SEG_1;
      DIG_2:    seg_c = SEG_2;
      DIG_3:    seg_c = SEG_3;
      DIG_4:    seg_c = SEG_4;
      DIG_5:    seg_c = SEG_5;
      DIG_6:    seg_c = SEG_6;
      DIG_7:    seg_c = SEG_7;
      DIG_8:    seg_c = SEG_8;
      DIG_9:    seg_c = SEG_9;
      DIG_DASH: seg_c = SEG_DASH;
      DIG_E:    seg_c = SEG_E;
      default:  seg_c = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/tube_time_display.sv
// Multiplexed 8-digit "HH-MM-SS" tube driver; time is snapshotted once per scan frame.
module tube_time_display
  import tube_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 25000,
  parameter int unsigned DIV_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FIELD_W-1:0] hour,
  input  logic [FIELD_W-1:0] minute,
  input  logic [FIELD_W-1:0] second,
  input  logic               blank,
  output logic [7:0]         an,
  output logic [SEG_W-1:0]   seg,
  output logic               frame_tick
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0]   div_q,    div_d;
  logic [IDX_W-1:0]   idx_q,    idx_d;
  logic [FIELD_W-1:0] hour_q,   hour_d;
  logic [FIELD_W-1:0] minute_q, minute_d;
  logic [FIELD_W-1:0] second_q, second_d;
  logic [7:0]         an_q,     an_d;
  logic [SEG_W-1:0]   seg_q,    seg_d;
  logic               tick_q,   tick_d;

  field_digits_t      hour_dig_c, minute_dig_c, second_dig_c;
  digit_e             dig_c;
  logic [SEG_W-1:0]   seg_dec_c;

  // Divider, digit index and frame-boundary snapshot.
  always_comb begin
    div_d    = div_q + DIV_W'(1);
    idx_d    = idx_q;
    hour_d   = hour_q;
    minute_d = minute_q;
    second_d = second_q;
    tick_d   = 1'b0;
    if (div_q == DIV_LAST) begin
      div_d = '0;
      idx_d = idx_q + 3'd1;
      if (idx_q == 3'd7) begin
        hour_d   = hour;
        minute_d = minute;
        second_d = second;
        tick_d   = 1'b1;
      end
    end
  end

  // Display works from next-state idx/snapshot so an/seg change on the same edge.
  always_comb begin
    hour_dig_c   = split_field(hour_d, HOUR_MAX);
    minute_dig_c = split_field(minute_d, MIN_MAX);
    second_dig_c = split_field(second_d, MIN_MAX);
    dig_c        = DIG_OFF;
    case (idx_d)
      3'd7: dig_c = hour_dig_c.tens;
      3'd6: dig_c = hour_dig_c.units;
      3'd5: dig_c = DIG_DASH;
      3'd4: dig_c = minute_dig_c.tens;
      3'd3: dig_c = minute_dig_c.units;
      3'd2: dig_c = DIG_DASH;
      3'd1: dig_c = second_dig_c.tens;
      3'd0: dig_c = second_dig_c.units;
      default: dig_c = DIG_OFF;
    endcase
    if (blank) begin
      dig_c = DIG_OFF;
    end
  end

  tube_seg_decode u_seg_decode (
    .code  (dig_c),
    .seg_c (seg_dec_c)
  );

  always_comb begin
    an_d  = blank ? 8'h00 : (8'd1 << idx_d);
    seg_d = seg_dec_c;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_q    <= '0;
      idx_q    <= '0;
      hour_q   <= '0;
      minute_q <= '0;
      second_q <= '0;
      an_q     <= 8'h00;
      seg_q    <= SEG_OFF;
      tick_q   <= 1'b0;
    end else begin
      div_q    <= div_d;
      idx_q    <= idx_d;
      hour_q   <= hour_d;
      minute_q <= minute_d;
      second_q <= second_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      tick_q   <= tick_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_tube_time_display.sv
// Directed bench for tube_time_display with SCAN_DIV=4 (32-cycle frames).
module tb_tube_time_display;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] hour = 6'd0;
  logic [5:0] minute = 6'd0;
  logic [5:0] second = 6'd0;
  logic       blank = 1'b0;
  logic [7:0] an;
  logic [7:0] seg;
  logic       frame_tick;

  int checks = 0;
  int failures = 0;

  logic [7:0] cap_an [8];
  logic [7:0] cap_seg [8];
  bit         cap_ok;
  logic [63:0] exp_v;

  tube_time_display #(
    .SCAN_DIV (4),
    .DIV_W    (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .hour       (hour),
    .minute     (minute),
    .second     (second),
    .blank      (blank),
    .an         (an),
    .seg        (seg),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  // Record the first sample of each digit of the frame starting at the next frame_tick.
  task automatic capture_frame();
    cap_ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (frame_tick === 1'b1) begin
        cap_ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (cap_ok) begin
      for (int d = 0; d < 8; d++) begin
        cap_an[d]  = an;
        cap_seg[d] = seg;
        repeat (4) @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; blank = 1'b0;
    hour = 6'd12; minute = 6'd34; second = 6'd56;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++;
    if (an !== 8'h00) begin failures++; $display("FAIL reset_an got=%02h want=00", an); end
    checks++;
    if (seg !== 8'h00) begin failures++; $display("FAIL reset_seg got=%02h want=00", seg); end
    checks++;
    if (frame_tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b want=0", frame_tick); end
    rst = 1'b1;
    exp_v = {8'h3F, 8'h3F, 8'h40, 8'h3F, 8'h3F, 8'h40, 8'h3F, 8'h3F};
    @(negedge clk);
    for (int d = 0; d < 8; d++) begin
      checks++;
      if (an !== (8'd1 << d) || seg !== exp_v[8*d +: 8]) begin
        failures++;
        $display("FAIL first_frame idx%0d an=%02h seg=%02h want an=%02h seg=%02h",
                 d, an, seg, 8'd1 << d, exp_v[8*d +: 8]);
      end
      repeat ((d == 0) ? 3 : 4) @(negedge clk);
    end
    checks++;
    if (frame_tick !== 1'b1) begin failures++; $display("FAIL first_tick_cycle32 got=%b want=1", frame_tick); end
  endtask

  task automatic test_decode_frame();
    exp_v = {8'h06, 8'h5B, 8'h40, 8'h4F, 8'h66, 8'h40, 8'h6D, 8'h7D};
    capture_frame();
    checks++;
    if (!cap_ok) begin failures++; $display("FAIL decode_frame timeout got=no_tick want=tick"); end
    for (int d = 0; d < 8; d++) begin
      checks++;
      if (cap_an[d] !== (8'd1 << d) || cap_seg[d] !== exp_v[8*d +: 8]) begin
        failures++;
        $display("FAIL decode_frame idx%0d an=%02h seg=%02h want an=%02h seg=%02h",
                 d, cap_an[d], cap_seg[d], 8'd1 << d, exp_v[8*d +: 8]);
      end
    end
  endtask

  task automatic test_mid_frame_change();
    @(negedge clk);
    checks++;
    if (frame_tick !== 1'b0) begin failures++; $display("FAIL tick_one_cycle got=%b want=0", frame_tick); end
    repeat (7) @(negedge clk);
    hour = 6'd13; second = 6'd57;
    repeat (16) @(negedge clk);
    checks++;
    if (an !== 8'h40 || seg !== 8'h5B) begin
      failures++; $display("FAIL mid_change_idx6 an=%02h seg=%02h want an=40 seg=5B", an, seg);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (an !== 8'h80 || seg !== 8'h06) begin
      failures++; $display("FAIL mid_change_idx7 an=%02h seg=%02h want an=80 seg=06", an, seg);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (frame_tick !== 1'b1 || an !== 8'h01 || seg !== 8'h07) begin
      failures++;
      $display("FAIL mid_change_next tick=%b an=%02h seg=%02h want tick=1 an=01 seg=07", frame_tick, an, seg);
    end
    exp_v = {8'h06, 8'h4F, 8'h40, 8'h4F, 8'h66, 8'h40, 8'h6D, 8'h07};
    capture_frame();
    checks++;
    if (!cap_ok) begin failures++; $display("FAIL mid_change_frame timeout got=no_tick want=tick"); end
    for (int d = 0; d < 8; d++) begin
      checks++;
      if (cap_an[d] !== (8'd1 << d) || cap_seg[d] !== exp_v[8*d +: 8]) begin
        failures++;
        $display("FAIL mid_change_frame idx%0d an=%02h seg=%02h want an=%02h seg=%02h",
                 d, cap_an[d], cap_seg[d], 8'd1 << d, exp_v[8*d +: 8]);
      end
    end
  endtask

  task automatic test_out_of_range();
    hour = 6'd24; minute = 6'd60; second = 6'd5;
    @(negedge clk);
    exp_v = {8'h79, 8'h79, 8'h40, 8'h79, 8'h79, 8'h40, 8'h3F, 8'h6D};
    capture_frame();
    checks++;
    if (!cap_ok) begin failures++; $display("FAIL oor_frame timeout got=no_tick want=tick"); end
    for (int d = 0; d < 8; d++) begin
      checks++;
      if (cap_an[d] !== (8'd1 << d) || cap_seg[d] !== exp_v[8*d +: 8]) begin
        failures++;
        $display("FAIL oor_frame idx%0d an=%02h seg=%02h want an=%02h seg=%02h",
                 d, cap_an[d], cap_seg[d], 8'd1 << d, exp_v[8*d +: 8]);
      end
    end
  endtask

  task automatic test_blank();
    hour = 6'd12; minute = 6'd34; second = 6'd56;
    repeat (10) @(negedge clk);
    blank = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (an !== 8'h00 || seg !== 8'h00 || frame_tick !== 1'b0) begin
        failures++;
        $display("FAIL blank_dark cyc%0d an=%02h seg=%02h tick=%b want 00 00 0", i, an, seg, frame_tick);
      end
    end
    blank = 1'b0;
    @(negedge clk);
    checks++;
    if (an !== 8'h20 || seg !== 8'h40) begin
      failures++; $display("FAIL blank_resume an=%02h seg=%02h want an=20 seg=40", an, seg);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (frame_tick !== 1'b0) begin failures++; $display("FAIL blank_tick_early got=%b want=0", frame_tick); end
    @(negedge clk);
    checks++;
    if (frame_tick !== 1'b1 || an !== 8'h01 || seg !== 8'h7D) begin
      failures++;
      $display("FAIL blank_tick_period tick=%b an=%02h seg=%02h want tick=1 an=01 seg=7D", frame_tick, an, seg);
    end
  endtask

  task automatic test_reset_mid_frame();
    repeat (20) @(negedge clk);
    checks++;
    if (an !== 8'h20) begin failures++; $display("FAIL pre_reset_idx5 an=%02h want=20", an); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (an !== 8'h00 || seg !== 8'h00 || frame_tick !== 1'b0) begin
      failures++; $display("FAIL mid_reset an=%02h seg=%02h tick=%b want 00 00 0", an, seg, frame_tick);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (an !== 8'h01 || seg !== 8'h3F) begin
      failures++; $display("FAIL post_reset_first an=%02h seg=%02h want an=01 seg=3F", an, seg);
    end
    repeat (27) @(negedge clk);
    checks++;
    if (an !== 8'h80 || seg !== 8'h3F) begin
      failures++; $display("FAIL post_reset_idx7 an=%02h seg=%02h want an=80 seg=3F", an, seg);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (frame_tick !== 1'b1 || seg !== 8'h7D) begin
      failures++; $display("FAIL post_reset_tick tick=%b seg=%02h want tick=1 seg=7D", frame_tick, seg);
    end
  endtask

  task automatic test_back_to_back_boundary();
    hour = 6'd23; minute = 6'd59; second = 6'd59;
    @(negedge clk);
    exp_v = {8'h5B, 8'h4F, 8'h40, 8'h6D, 8'h6F, 8'h40, 8'h6D, 8'h6F};
    capture_frame();
    checks++;
    if (!cap_ok) begin failures++; $display("FAIL max_frame timeout got=no_tick want=tick"); end
    for (int d = 0; d < 8; d++) begin
      checks++;
      if (cap_an[d] !== (8'd1 << d) || cap_seg[d] !== exp_v[8*d +: 8]) begin
        failures++;
        $display("FAIL max_frame idx%0d an=%02h seg=%02h want an=%02h seg=%02h",
                 d, cap_an[d], cap_seg[d], 8'd1 << d, exp_v[8*d +: 8]);
      end
    end
    hour = 6'd0; minute = 6'd0; second = 6'd0;
    @(negedge clk);
    exp_v = {8'h3F, 8'h3F, 8'h40, 8'h3F, 8'h3F, 8'h40, 8'h3F, 8'h3F};
    capture_frame();
    checks++;
    if (!cap_ok) begin failures++; $display("FAIL zero_frame timeout got=no_tick want=tick"); end
    for (int d = 0; d < 8; d++) begin
      checks++;
      if (cap_an[d] !== (8'd1 << d) || cap_seg[d] !== exp_v[8*d +: 8]) begin
        failures++;
        $display("FAIL zero_frame idx%0d an=%02h seg=%02h want an=%02h seg=%02h",
                 d, cap_an[d], cap_seg[d], 8'd1 << d, exp_v[8*d +: 8]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_decode_frame();
    test_mid_frame_change();
    test_out_of_range();
    test_blank();
    test_reset_mid_frame();
    test_back_to_back_boundary();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tube_time_display.md
Name: tube_time_display

Overview:
- Downstream consumer of the timekeeping block.
- Takes binary hour/minute/second (6 b each) and drives an 8-digit multiplexed seven-segment tube as "HH-MM-SS".
- Snapshots the time once per scan frame, so a frame never mixes old and new values.
- Converts each field to two decimal digits and scans one digit at a time at a programmable rate.

Parameters:
- SCAN_DIV, 25000, clk cycles each digit stays lit (frame = 8*SCAN_DIV cycles); legal range 2..65535.
- DIV_W, 16, width of the scan divider counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-low.
- hour  in  6  binary hour, legal 0..23.
- minute  in  6  binary minute, legal 0..59.
- second  in  6  binary second, legal 0..59.
- blank  in  1  1 = all digits dark; scanning continues.
- an  out  8  one-hot digit enable, active-high; bit 7 = leftmost digit.
- seg  out  8  segments {dp,g,f,e,d,c,b,a}, active-high.
- frame_tick  out  1  one-cycle pulse on each frame start (snapshot load).

Behaviour:
- Reset (rst=0 at a clk edge):
  - div=0, idx=0, snapshot h/m/s=0, frame_tick=0.
  - an=8'h00, seg=8'h00.
  - Reset mid-frame aborts the frame; no partial state survives.
- Divider:
  - div counts 0..SCAN_DIV-1, then wraps.
  - At div==SCAN_DIV-1, idx advances 0→1→…→7→0 (mod 8).
- Frame boundary (div==SCAN_DIV-1 and idx==7), on that edge:
  - Snapshot loads hour/minute/second.
  - idx becomes 0.
  - frame_tick=1 for exactly that one cycle.
- First frame after reset release: idx=0 with the zero snapshot; no snapshot load until the first wrap.
- an/seg are registered and change on the same edge as idx and snapshot, using the next-state values. No extra latency.
- First cycle after reset release: an=8'h01, seg=8'h3F ('0').
- Digit map, idx 7..0:
  - H tens, H units, dash, M tens, M units, dash, S tens, S units.
  - an = 1<<idx.
- BCD conversion, per 6-bit field:
  - tens = v/10, units = v%10.
  - Pure combinational; constant divide-by-10 on 6 bits, no iterative divider.
- Out-of-range fields show "EE" on both digits of that field only:
  - hour >= 24, minute >= 60, or second >= 60.
- Leading zeros are shown (e.g. 05).
- Segment codes:
  - Digits: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - dash=40, E=79, dark=00. dp is always 0.
- blank=1: next edge an=8'h00, seg=8'h00. div, idx, snapshot and frame_tick continue unaffected.
- blank falling: next edge resumes display at the current idx.
- Input changes mid-frame are invisible until the next frame boundary.

Decomposition:
- Shared package (tube_pkg):
  - Segment code constants SEG_0..SEG_9, SEG_DASH, SEG_E, SEG_OFF.
  - Digit-code enum of 4 bits (0-9 digits, DASH=10, E=11, OFF=15).
  - Limits HOUR_MAX=23, MIN_MAX=59.
- One natural sub-module: tube_seg_decode, combinational, 4-bit digit code → 8-bit seg.
- Divider, idx, snapshot, BCD split and mux stay in the top.

Test Plan (SCAN_DIV=4 in sim):
- Reset, hold rst=0 5 cycles, release with inputs 12/34/56 → first frame shows 00-00-00 (an 01,02,…,80 every 4 cycles, seg 3F/3F/40/3F/3F/40/3F/3F). frame_tick pulses at cycle 32; next frame digits idx7..0 = 5B?no: 06,5B,40,4F,66,40,6D,7D.
- Change second 56→57 at cycle 40 (mid-frame) → current frame still shows 6 (7D) at idx0. Next frame shows 07 at idx0.
- hour=24, minute=60, second=5 → idx7/6 = 79,79; idx5 = 40; idx4/3 = 79,79; idx1/0 = 3F,6D.
- blank=1 for 10 cycles mid-frame → an=00, seg=00 from the next edge. frame_tick period unchanged (32 cycles). Display resumes at the correct idx after release.
- Assert rst=0 during idx=5 → next edge an=00, seg=00, frame_tick=0. After release an=01, snapshot=0.
- Boundary values 23/59/59 then 0/0/0 → "23-59-59" then "00-00-00", each shown for a full frame with no mixed digits.
